// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: pops the receiver FIFO one byte at a time, folds
// E0/F0 prefixes into single key events and tracks the held key for typematic.
module ps2_key_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned TO_W           = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       kb_ready,
    input  logic [7:0] kb_data,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_repeat,
    output logic [7:0] press_count,
    output logic       err_overflow,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 32'd1);

    state_e          state_q,       state_d;
    logic            nextdata_n_q,  nextdata_n_d;
    logic            ev_valid_q,    ev_valid_d;
    logic [7:0]      ev_code_q,     ev_code_d;
    logic            ev_ext_q,      ev_ext_d;
    logic            ev_break_q,    ev_break_d;
    logic            ev_repeat_q,   ev_repeat_d;
    logic [7:0]      press_count_q, press_count_d;
    logic            err_ov_q,      err_ov_d;
    logic            err_to_q,      err_to_d;
    logic            ext_q,         ext_d;
    logic            brk_q,         brk_d;
    logic [7:0]      held_code_q,   held_code_d;
    logic            held_ext_q,    held_ext_d;
    logic            held_v_q,      held_v_d;
    logic [TO_W-1:0] to_cnt_q,      to_cnt_d;

    logic can_load_s;
    logic pending_s;
    logic to_run_s;
    logic held_hit_s;

    function automatic logic key_match(input logic       v,
                                       input logic [7:0] hc,
                                       input logic       he,
                                       input logic [7:0] c,
                                       input logic       e);
        return v && (hc == c) && (he == e);
    endfunction

    // Next-state logic: pop handshake, byte parsing, held-key record, timeout.
    always_comb begin
        state_d       = state_q;
        nextdata_n_d  = 1'b1;
        ev_valid_d    = ev_valid_q;
        ev_code_d     = ev_code_q;
        ev_ext_d      = ev_ext_q;
        ev_break_d    = ev_break_q;
        ev_repeat_d   = ev_repeat_q;
        press_count_d = press_count_q;
        err_ov_d      = err_ov_q | kb_overflow;
        err_to_d      = err_to_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        held_code_d   = held_code_q;
        held_ext_d    = held_ext_q;
        held_v_d      = held_v_q;
        to_cnt_d      = to_cnt_q;

        can_load_s = !ev_valid_q || ev_ready;
        pending_s  = ext_q || brk_q;
        to_run_s   = pending_s && (state_q == ST_IDLE) && !kb_ready;
        held_hit_s = key_match(held_v_q, held_code_q, held_ext_q, kb_data, ext_q);

        if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end else begin
            ev_valid_d = ev_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (kb_ready && can_load_s) begin
                    state_d      = ST_POP;
                    nextdata_n_d = 1'b0;
                end else begin
                    state_d      = ST_IDLE;
                    nextdata_n_d = 1'b1;
                end
            end
            ST_POP: begin
                state_d = ST_GAP;
                if (kb_data == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (kb_data == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    // A load overrides a coincident handshake, so valid stays high.
                    ev_valid_d  = 1'b1;
                    ev_code_d   = kb_data;
                    ev_ext_d    = ext_q;
                    ev_break_d  = brk_q;
                    ev_repeat_d = 1'b0;
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                    if (brk_q) begin
                        if (held_hit_s) begin
                            held_v_d = 1'b0;
                        end else begin
                            held_v_d = held_v_q;
                        end
                    end else if (held_hit_s) begin
                        ev_repeat_d = 1'b1;
                    end else begin
                        press_count_d = press_count_q + 8'd1;
                        held_code_d   = kb_data;
                        held_ext_d    = ext_q;
                        held_v_d      = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter only advances while a prefix waits on an empty FIFO.
        if (state_q == ST_POP) begin
            to_cnt_d = '0;
        end else if (!pending_s) begin
            to_cnt_d = '0;
        end else if (to_run_s) begin
            if (to_cnt_q == TO_LAST) begin
                to_cnt_d = '0;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
                err_to_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1'b1);
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            ev_valid_q    <= 1'b0;
            ev_code_q     <= 8'h00;
            ev_ext_q      <= 1'b0;
            ev_break_q    <= 1'b0;
            ev_repeat_q   <= 1'b0;
            press_count_q <= 8'h00;
            err_ov_q      <= 1'b0;
            err_to_q      <= 1'b0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
            held_v_q      <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            nextdata_n_q  <= nextdata_n_d;
            ev_valid_q    <= ev_valid_d;
            ev_code_q     <= ev_code_d;
            ev_ext_q      <= ev_ext_d;
            ev_break_q    <= ev_break_d;
            ev_repeat_q   <= ev_repeat_d;
            press_count_q <= press_count_d;
            err_ov_q      <= err_ov_d;
            err_to_q      <= err_to_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            held_code_q   <= held_code_d;
            held_ext_q    <= held_ext_d;
            held_v_q      <= held_v_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign ev_valid      = ev_valid_q;
    assign ev_code       = ev_code_q;
    assign ev_ext        = ev_ext_q;
    assign ev_break      = ev_break_q;
    assign ev_repeat     = ev_repeat_q;
    assign press_count   = press_count_q;
    assign err_overflow  = err_ov_q;
    assign err_timeout   = err_to_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: emulated receiver FIFO, event-level reference
// model checked every cycle, plus directed literal expectations.
module tb_ps2_key_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       kb_ready = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_overflow = 1'b0;
    logic       ev_ready = 1'b1;
    logic       kb_nextdata_n, ev_valid, ev_ext, ev_break, ev_repeat;
    logic       err_overflow, err_timeout;
    logic [7:0] ev_code, press_count;

    ps2_key_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(4)) dut (
        .clk(clk), .rstn(rstn), .kb_ready(kb_ready), .kb_data(kb_data),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
        .ev_ext(ev_ext), .ev_break(ev_break), .ev_repeat(ev_repeat),
        .press_count(press_count), .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] c, input logic e, input logic b, input logic r);
        return {c, e, b, r};
    endfunction

    // Receiver FIFO contents and the reference model of the sequencer.
    logic [7:0]  fifo[$];
    logic [10:0] exp_q[$];
    logic [10:0] dlog[$];
    logic        m_ext, m_brk, m_held_v, m_err_ov, m_err_to;
    logic [8:0]  m_held;
    logic [7:0]  m_cnt;
    int          since, m_run, npop, t_pop0, t_val0;
    bit          gap_pop, prev_nd, prev_blk, prev_rdy;

    task automatic model_parse(input logic [7:0] b);
        logic rep;
        rep = 1'b0;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_brk) begin
                if (m_held_v && m_held == {b, m_ext}) rep = 1'b1;
                else begin
                    m_cnt    = m_cnt + 8'd1;
                    m_held   = {b, m_ext};
                    m_held_v = 1'b1;
                end
            end else if (m_held_v && m_held == {b, m_ext}) m_held_v = 1'b0;
            exp_q.push_back({b, m_ext, m_brk, rep});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            m_ext = 1'b0; m_brk = 1'b0; m_held_v = 1'b0; m_held = 9'h000;
            m_cnt = 8'h00; m_err_ov = 1'b0; m_err_to = 1'b0;
            since = 2; m_run = 0; npop = 0; gap_pop = 1'b0;
            prev_nd = 1'b1; prev_blk = 1'b0; prev_rdy = 1'b0;
            kb_ready = 1'b0;
            kb_data  = 8'h00;
        end else begin
            chk("ev_valid", {31'd0, ev_valid}, {31'd0, exp_q.size() != 0});
            if (ev_valid && exp_q.size() != 0)
                chk("event", {21'd0, ev_code, ev_ext, ev_break, ev_repeat}, {21'd0, exp_q[0]});
            chk("press_count", {24'd0, press_count}, {24'd0, m_cnt});
            chk("err_overflow", {31'd0, err_overflow}, {31'd0, m_err_ov});
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_err_to});
            if (t_val0 < 0 && ev_valid) t_val0 = cyc;
            if (ev_valid && ev_ready) begin
                dlog.push_back({ev_code, ev_ext, ev_break, ev_repeat});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (kb_overflow) m_err_ov = 1'b1;
            if (gap_pop) begin
                gap_pop = 1'b0;
                if (fifo.size() != 0) void'(fifo.pop_front());
            end
            kb_ready = (fifo.size() != 0);
            kb_data  = kb_ready ? fifo[0] : 8'h00;
            if (!kb_nextdata_n) begin
                npop++;
                if (t_pop0 < 0) t_pop0 = cyc;
                chk("pop_single_cycle", {31'd0, prev_nd}, 32'd1);
                chk("pop_allowed", {31'd0, prev_rdy && !prev_blk}, 32'd1);
                chk("pop_nonempty", {31'd0, fifo.size() != 0}, 32'd1);
                model_parse(kb_data);
                since   = 0;
                m_run   = 0;
                gap_pop = 1'b1;
            end else begin
                since++;
                if (m_ext || m_brk) begin
                    if (since >= 2 && !kb_ready) begin
                        m_run++;
                        if (m_run == TO) begin
                            m_ext = 1'b0; m_brk = 1'b0; m_err_to = 1'b1; m_run = 0;
                        end
                    end
                end else m_run = 0;
            end
            prev_nd  = kb_nextdata_n;
            prev_blk = ev_valid && !ev_ready;
            prev_rdy = kb_ready;
        end
    end

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
    endtask

    task automatic waitc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        fifo.delete();
        dlog.delete();
        kb_overflow = 1'b0;
        ev_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int seen;
        t_pop0 = -1;
        t_val0 = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_nextdata_n", {31'd0, kb_nextdata_n}, 32'd1);
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_ev_fields", {28'd0, ev_code == 8'h00, ev_ext, ev_break, ev_repeat}, 32'h8);
        chk("rst_press_count", {24'd0, press_count}, 32'd0);
        chk("rst_errs", {30'd0, err_overflow, err_timeout}, 32'd0);
        rstn = 1'b1;
        waitc(2);

        // Make then break of 1C, with first-byte latency.
        t_pop0 = -1; t_val0 = -1; t0 = cyc;
        push(8'h1C); push(8'hF0); push(8'h1C);
        waitc(20);
        chk("t1_pop_latency", t_pop0 - t0, 32'd1);
        chk("t1_valid_latency", t_val0 - t0, 32'd2);
        chk("t1_pop_count", npop, 32'd3);
        chk("t1_n_events", dlog.size(), 32'd2);
        chk("t1_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h1C, 1'b0, 1'b0, 1'b0)});
        chk("t1_ev1", {21'd0, dlog[1]}, {21'd0, mk(8'h1C, 1'b0, 1'b1, 1'b0)});
        chk("t1_press", {24'd0, press_count}, 32'd1);

        // Extended key make and break with a repeated prefix.
        do_reset();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        waitc(25);
        chk("t2_n_events", dlog.size(), 32'd2);
        chk("t2_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h75, 1'b1, 1'b0, 1'b0)});
        chk("t2_ev1", {21'd0, dlog[1]}, {21'd0, mk(8'h75, 1'b1, 1'b1, 1'b0)});
        chk("t2_press", {24'd0, press_count}, 32'd1);

        // Pre-filled three-byte break sequence latency.
        do_reset();
        t_val0 = -1; t0 = cyc;
        push(8'hE0); push(8'hF0); push(8'h14);
        waitc(15);
        chk("t2b_valid_latency", t_val0 - t0, 32'd8);
        chk("t2b_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h14, 1'b1, 1'b1, 1'b0)});
        chk("t2b_press", {24'd0, press_count}, 32'd0);

        // Typematic repeats.
        do_reset();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        waitc(25);
        chk("t3_n_events", dlog.size(), 32'd4);
        chk("t3_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h1C, 1'b0, 1'b0, 1'b0)});
        chk("t3_ev1", {21'd0, dlog[1]}, {21'd0, mk(8'h1C, 1'b0, 1'b0, 1'b1)});
        chk("t3_ev2", {21'd0, dlog[2]}, {21'd0, mk(8'h1C, 1'b0, 1'b0, 1'b1)});
        chk("t3_ev3", {21'd0, dlog[3]}, {21'd0, mk(8'h1C, 1'b0, 1'b1, 1'b0)});
        chk("t3_press", {24'd0, press_count}, 32'd1);

        // Backpressure holds the first event and stops popping.
        do_reset();
        ev_ready = 1'b0;
        push(8'h15); push(8'h16); push(8'h17);
        waitc(20);
        chk("t4_pop_held", npop, 32'd1);
        chk("t4_valid_held", {31'd0, ev_valid}, 32'd1);
        chk("t4_code_held", {24'd0, ev_code}, 32'h15);
        chk("t4_nextdata_high", {31'd0, kb_nextdata_n}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            ev_ready = 1'b1;
            @(posedge clk);
            #1 ev_ready = 1'b0;
            waitc(6);
        end
        chk("t4_n_events", dlog.size(), 32'd3);
        chk("t4_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h15, 1'b0, 1'b0, 1'b0)});
        chk("t4_ev1", {21'd0, dlog[1]}, {21'd0, mk(8'h16, 1'b0, 1'b0, 1'b0)});
        chk("t4_ev2", {21'd0, dlog[2]}, {21'd0, mk(8'h17, 1'b0, 1'b0, 1'b0)});
        chk("t4_press", {24'd0, press_count}, 32'd3);
        ev_ready = 1'b1;

        // Dangling F0 times out; following byte is a plain make.
        do_reset();
        push(8'hF0);
        waitc(16);
        chk("t5_err_timeout", {31'd0, err_timeout}, 32'd1);
        chk("t5_no_event", dlog.size(), 32'd0);
        push(8'h1C);
        waitc(6);
        chk("t5_ev0", {21'd0, dlog[0]}, {21'd0, mk(8'h1C, 1'b0, 1'b0, 1'b0)});
        chk("t5_press", {24'd0, press_count}, 32'd1);

        // Sticky overflow flag.
        kb_overflow = 1'b1;
        @(posedge clk);
        #1 kb_overflow = 1'b0;
        chk("t6_err_overflow", {31'd0, err_overflow}, 32'd1);
        waitc(10);
        chk("t6_err_overflow_sticky", {31'd0, err_overflow}, 32'd1);

        // press_count wraps after 256 distinct makes.
        do_reset();
        for (int i = 0; i < 256; i++) push(i[0] ? 8'h1B : 8'h1C);
        waitc(800);
        chk("t7_pop_count", npop, 32'd256);
        chk("t7_n_events", dlog.size(), 32'd256);
        chk("t7_press_wrap", {24'd0, press_count}, 32'd0);

        // Asynchronous reset in the middle of a pop.
        do_reset();
        kb_overflow = 1'b1;
        @(posedge clk);
        #1 kb_overflow = 1'b0;
        push(8'h1C); push(8'h2A);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (!kb_nextdata_n) begin
                seen++;
                if (seen == 2) break;
            end
        end
        chk("t8_second_pop_seen", seen, 32'd2);
        rstn = 1'b0;
        #1;
        chk("t8_nextdata_n", {31'd0, kb_nextdata_n}, 32'd1);
        chk("t8_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("t8_ev_fields", {28'd0, ev_code == 8'h00, ev_ext, ev_break, ev_repeat}, 32'h8);
        chk("t8_press", {24'd0, press_count}, 32'd0);
        chk("t8_errs", {30'd0, err_overflow, err_timeout}, 32'd0);
        fifo.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        waitc(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Controller between the PS/2 keyboard receiver's scan-code FIFO and the key-processing and display logic. It owns the FIFO read handshake, popping one byte at a time only when downstream can accept it. It folds E0/F0 prefixes into single key events, suppresses typematic repeats from the press count, and recovers from truncated prefix sequences with a timeout. Downstream consumers receive one decoded event per key action over a valid/ready interface.

## Interface
- TIMEOUT_CYCLES, 1_000_000, idle cycles after a prefix byte before the pending prefix is discarded; minimum 4
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

- clk  in  1  single system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- kb_ready  in  1  receiver FIFO non-empty; kb_data valid while high
- kb_data  in  8  scan byte at FIFO head
- kb_overflow  in  1  receiver FIFO overflow flag
- kb_nextdata_n  out  1  active-low pop strobe to receiver, registered
- ev_valid  out  1  event register holds an undelivered event
- ev_ready  in  1  downstream accepts the event this cycle
- ev_code  out  8  final, non-prefix scan code
- ev_ext  out  1  event was preceded by E0
- ev_break  out  1  event was preceded by F0 (release)
- ev_repeat  out  1  make event for the key already held (typematic)
- press_count  out  8  count of non-repeat make events, wraps 255->0
- err_overflow  out  1  sticky, set when kb_overflow sampled high
- err_timeout  out  1  sticky, set when a pending prefix times out

## Operation
- Reset values: kb_nextdata_n=1, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_repeat=0, press_count=0, err_overflow=0, err_timeout=0, FSM=IDLE, prefix flags clear, held-key record empty, timeout counter 0.
- Pop FSM states IDLE, POP, GAP.
  - IDLE -> POP when kb_ready=1 and the event register can load, i.e. ev_valid=0 or ev_ready=1 in that cycle. The register drives kb_nextdata_n=0 during POP.
  - POP: kb_data is sampled and parsed in this cycle, which is the only cycle kb_nextdata_n is low. Always goes to GAP.
  - GAP: kb_nextdata_n=1 for one cycle so the receiver can advance its read pointer. Always goes to IDLE.
  - Maximum consumption rate is 1 byte per 3 cycles.
- Byte parsing in POP:
  - E0: set ext flag; no event.
  - F0: set brk flag; no event.
  - Any other byte: load the event register with code and flags, set ev_valid, then clear both flags.
  - Repeated prefixes are idempotent: E0 E0 behaves like E0.
- Held-key tracking, where held key is {code, ext} plus a valid bit:
  - Make event matching the held key: ev_repeat=1, press_count unchanged.
  - Make event with a different key: ev_repeat=0, press_count+1, held key replaced.
  - Break event matching the held key: held key cleared. ev_repeat=0 on all break events.
- Event register: ev_valid drops on the cycle after ev_valid&&ev_ready. If a load and a handshake coincide, the new event wins and ev_valid stays 1. ev_* fields are stable while ev_valid=1 and ev_ready=0.
- Timeout:
  - The counter runs only while a prefix flag is set and the FSM is in IDLE with kb_ready=0; it resets on any pop.
  - When it reaches TIMEOUT_CYCLES-1: clear both flags, set err_timeout, emit no event.
- err_overflow and err_timeout clear only on reset.
- Reset mid-operation: asynchronous; all state returns to reset values immediately, including mid-POP, where kb_nextdata_n returns to 1.

## Timing
- Byte at FIFO head with kb_ready=1 in IDLE at cycle T: kb_nextdata_n=0 at T+1, ev_valid=1 at T+2 for a non-prefix byte.
- 3-byte break sequence E0 F0 xx with the FIFO pre-filled: ev_valid rises 8 cycles after the first IDLE-with-ready cycle.
- Backpressure: while ev_valid=1 and ev_ready=0, no pop occurs and kb_nextdata_n stays 1, so FIFO data is never lost in the sequencer.
- press_count and the held-key record update in the same cycle ev_valid rises.
- err_overflow is set the cycle after kb_overflow is sampled high.

## Test plan
- Reset, then FIFO bytes 1C, F0, 1C with ev_ready=1 → events {1C, ext0, brk0, rep0} then {1C, ext0, brk1, rep0}; press_count=1; kb_nextdata_n low exactly 3 single cycles.
- Bytes E0 75 E0 F0 75 → events {75, ext1, brk0} then {75, ext1, brk1}; press_count=1.
- Typematic: 1C 1C 1C F0 1C → three make events with ev_repeat 0, 1, 1, then a break; press_count=1.
- Backpressure: ev_ready=0 for 20 cycles with 3 non-prefix bytes queued → first event held stable, kb_nextdata_n stays 1 after the first pop; each later ev_ready pulse delivers the next event in order.
- Timeout with TIMEOUT_CYCLES=8: byte F0, then FIFO empty for 10 cycles, then 1C → err_timeout=1 and the event is {1C, brk0}, a make.
- kb_overflow pulse → err_overflow=1 persists; 256 distinct alternating make events → press_count wraps to 0; asserting rstn=0 mid-POP → all outputs return to reset values asynchronously.
